// File: rtl/univ_shift_reg_nbit_if.sv
// univ_shift_reg_nbit_if: control, data and status bundle for the universal shift register.
interface univ_shift_reg_nbit_if #(parameter int N = 8);
   logic         en_in;
   logic [2:0]   mode_in;
   logic [N-1:0] d_in;
   logic         sin_lsb_in;
   logic         sin_msb_in;
   logic         start_in;
   logic [N-1:0] q_out;
   logic         sout_msb_out;
   logic         sout_lsb_out;
   logic         busy_out;
   logic         done_out;
   modport master (
      output en_in, mode_in, d_in, sin_lsb_in, sin_msb_in, start_in,
      input  q_out, sout_msb_out, sout_lsb_out, busy_out, done_out
   );
   modport slave (
      input  en_in, mode_in, d_in, sin_lsb_in, sin_msb_in, start_in,
      output q_out, sout_msb_out, sout_lsb_out, busy_out, done_out
   );
endinterface

// File: rtl/univ_shift_reg_nbit.sv
// univ_shift_reg_nbit: N-bit universal register with a load-then-shift-N-bits burst sequencer.
module univ_shift_reg_nbit #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                clk,
   input logic                reset_al_in,
   univ_shift_reg_nbit_if.slave bus
);
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [N-1:0]  q, q_nx, mode_q, burst_q;
   logic          last;
   always_comb begin
      mode_q = q;
      case (bus.mode_in)
         3'b001: mode_q = bus.d_in;
         3'b010: mode_q = {q[N-2:0], bus.sin_lsb_in};
         3'b011: mode_q = {bus.sin_msb_in, q[N-1:1]};
         3'b100: mode_q = {q[N-2:0], q[N-1]};
         3'b101: mode_q = {q[0], q[N-1:1]};
         3'b110: mode_q = {q[N-1], q[N-1:1]};
         3'b111: mode_q = '0;
         default: mode_q = q;
      endcase
   end
   assign burst_q = MSB_FIRST ? {q[N-2:0], bus.sin_lsb_in} : {bus.sin_msb_in, q[N-1:1]};
   assign last    = cnt == CW'(N - 1);
   // DONE always falls back to IDLE, but with en_in it also acts exactly like IDLE.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      q_nx     = q;
      if (state == SHIFT) begin
         if (bus.en_in) begin
            q_nx     = burst_q;
            cnt_nx   = last ? '0 : cnt + 1'b1;
            state_nx = last ? DONE : SHIFT;
         end
      end else begin
         if (state == DONE) state_nx = IDLE;
         if (bus.en_in && bus.start_in) begin
            q_nx     = bus.d_in;
            cnt_nx   = '0;
            state_nx = SHIFT;
         end else if (bus.en_in) q_nx = mode_q;
      end
   end
   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         state <= IDLE;
         cnt   <= '0;
         q     <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         q     <= q_nx;
      end
   end
   assign bus.q_out        = q;
   assign bus.sout_msb_out = q[N-1];
   assign bus.sout_lsb_out = q[0];
   assign bus.busy_out     = state == SHIFT;
   assign bus.done_out     = state == DONE;
endmodule
